// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial A - B, LSB first, one difference/borrow cell per clock with a
// registered borrow. A start/busy/done handshake allows back-to-back runs.
//
// Handshake: start is sampled on the rising edge only while the block is in
// IDLE or DONE; that edge loads a and b. busy is high for exactly WIDTH
// cycles afterwards, then done pulses for one cycle with diff/borrow valid.
// start seen during RUN is ignored. diff and borrow hold in IDLE until the
// next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter must be able to index bit WIDTH-1; never narrower than one bit.
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_shift;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the last RUN edge is the one that processes bit WIDTH-1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_next = DONE_S;
      DONE_S:  state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accept start only when no operation is in flight.
  assign load = start && ((state == IDLE) || (state == DONE_S));

  // One difference/borrow cell plus the right-shifted result with d in the MSB.
  always_comb begin
    a0         = a_q[0];
    b0         = b_q[0];
    d_bit      = a0 ^ b0 ^ br_q;
    br_next    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    diff_shift = diff_q >> 1;
    diff_shift[WIDTH-1] = d_bit;
  end

  // Operand/result shift registers, borrow register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      a_q    <= a;
      b_q    <= b;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (state == RUN) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      diff_q <= diff_shift;
      br_q   <= br_next;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Registered status flags so busy/done come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE_S);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH = 4, 1 and 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;
  logic       start1, busy1, done1, borrow1;
  logic [0:0] a1, b1, diff1;
  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;

  int n_vec;
  int n_err;
  logic [8:0] exp_q[$];

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch on WIDTH=4; returns right after the accepting edge (at the next negedge).
  task automatic launch4(input logic [3:0] av, input logic [3:0] bv, input logic [4:0] exp);
    start4 = 1'b1; a4 = av; b4 = bv;
    exp_q.push_back({4'b0, exp});
    @(negedge clk);
    start4 = 1'b0; a4 = $urandom_range(15, 0); b4 = $urandom_range(15, 0);
  endtask

  // Expect WIDTH busy cycles then a done pulse matching the queue head.
  task automatic finish4(input string tag, input bit restart, input logic [3:0] av,
                         input logic [3:0] bv, input logic [4:0] nexp);
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, {31'b0, busy4}, 32'd1);
      check({tag, "_nodone"}, {31'b0, done4}, 32'd0);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({tag, "_done"}, {31'b0, done4}, 32'd1);
    check({tag, "_busy_lo"}, {31'b0, busy4}, 32'd0);
    check({tag, "_diff"}, {28'b0, diff4}, {28'b0, e[3:0]});
    check({tag, "_borrow"}, {31'b0, borrow4}, {31'b0, e[4]});
    if (restart) begin
      launch4(av, bv, nexp);
    end else begin
      @(negedge clk);
      check({tag, "_pulse"}, {31'b0, done4}, 32'd0);
      check({tag, "_hold"}, {27'b0, borrow4, diff4}, {27'b0, e[4:0]});
    end
  endtask

  task automatic run1(input string tag, input logic av, input logic bv,
                      input logic ed, input logic eb);
    start1 = 1'b1; a1 = av; b1 = bv;
    @(negedge clk);
    start1 = 1'b0;
    check({tag, "_busy"}, {31'b0, busy1}, 32'd1);
    @(negedge clk);
    check({tag, "_done"}, {31'b0, done1}, 32'd1);
    check({tag, "_diff"}, {31'b0, diff1}, {31'b0, ed});
    check({tag, "_borrow"}, {31'b0, borrow1}, {31'b0, eb});
    @(negedge clk);
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {31'b0, busy8}, 32'd1);
      @(negedge clk);
    end
    check({tag, "_done"}, {31'b0, done8}, 32'd1);
    check({tag, "_diff"}, {24'b0, diff8}, {24'b0, ed});
    check({tag, "_borrow"}, {31'b0, borrow8}, {31'b0, eb});
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    start4 = 0; a4 = 0; b4 = 0;
    start1 = 0; a1 = 0; b1 = 0;
    start8 = 0; a8 = 0; b8 = 0;
    #12;
    check("rst_out4", {25'b0, busy4, done4, borrow4, diff4}, 32'd0);
    check("rst_out8", {21'b0, busy8, done8, borrow8, diff8}, 32'd0);
    check("rst_out1", {28'b0, busy1, done1, borrow1, diff1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and borrow cases.
    launch4(4'd5, 4'd3, 5'b0_0010);   finish4("b5m3", 0, 0, 0, 0);
    launch4(4'd3, 4'd5, 5'b1_1110);   finish4("b3m5", 0, 0, 0, 0);
    launch4(4'd0, 4'd0, 5'b0_0000);   finish4("b0m0", 0, 0, 0, 0);
    launch4(4'd15, 4'd15, 5'b0_0000); finish4("b15m15", 0, 0, 0, 0);

    // start during RUN is ignored.
    launch4(4'd9, 4'd4, 5'b0_0101);
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
    @(negedge clk);
    start4 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        dcount++;
        check("ign_diff", {28'b0, diff4}, 32'd5);
        check("ign_borrow", {31'b0, borrow4}, 32'd0);
      end
      @(negedge clk);
    end
    check("ign_done_count", dcount, 32'd1);
    void'(exp_q.pop_front());

    // Back-to-back: 12-7 then 2-6 launched during DONE.
    launch4(4'd12, 4'd7, 5'b0_0101);
    finish4("bb1", 1, 4'd2, 4'd6, 5'b1_1100);
    finish4("bb2", 0, 0, 0, 0);

    // Single-bit truth table.
    run1("t00", 1'b0, 1'b0, 1'b0, 1'b0);
    run1("t01", 1'b0, 1'b1, 1'b1, 1'b1);
    run1("t10", 1'b1, 1'b0, 1'b1, 1'b0);
    run1("t11", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation on WIDTH=8.
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_busy", {31'b0, busy8}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out", {21'b0, busy8, done8, borrow8, diff8}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8) dcount++;
    end
    check("mid_no_done", dcount, 32'd0);
    rst_n = 1'b1;
    run8("r100m1", 8'd100, 8'd1, 8'd99, 1'b0);
    run8("r3m200", 8'd3, 8'd200, 8'd59, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
